// File: rtl/hc595_rx.sv
// hc595_rx: receiver/deserializer for a 74HC595-style serial link.
// The four link wires are oversampled in the clk domain. A rising SHCP edge
// shifts DS into the shift register, and a rising STCP edge copies the shift
// register into the storage register. Each latch also produces a one-cycle
// valid pulse and a check that exactly WIDTH bits were shifted.
//
// Handshake: o_valid is a single-cycle strobe with no ready/backpressure.
// It is high for exactly the clk cycle in which o_data holds a freshly
// latched frame. o_frame_err is qualified by that same cycle and holds its
// value until the next latch.
module hc595_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_stcp,
    input  logic                          i_shcp,
    input  logic                          i_ds,
    input  logic                          i_oe,
    output logic [WIDTH-1:0]              o_shift,
    output logic [WIDTH-1:0]              o_data,
    output logic [WIDTH-1:0]              o_q,
    output logic                          o_valid,
    output logic                          o_frame_err,
    output logic [$clog2(WIDTH+2)-1:0]    o_bit_cnt
);

    localparam int              CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchronizer chains. Bit 0 is the first stage. All four chains have
    // the same depth, so DS stays cycle-aligned with the SHCP edge that
    // qualifies it.
    logic [SYNC_STAGES-1:0] r_stcp_sync;
    logic [SYNC_STAGES-1:0] r_shcp_sync;
    logic [SYNC_STAGES-1:0] r_ds_sync;
    logic [SYNC_STAGES-1:0] r_oe_sync;
    logic                   r_stcp_prev;
    logic                   r_shcp_prev;

    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic [CNT_W-1:0]       r_bit_cnt;

    logic                   w_stcp;
    logic                   w_shcp;
    logic                   w_ds;
    logic                   w_oe_n;
    logic                   w_stcp_rise;
    logic                   w_shcp_rise;

    assign w_stcp      = r_stcp_sync[SYNC_STAGES-1];
    assign w_shcp      = r_shcp_sync[SYNC_STAGES-1];
    assign w_ds        = r_ds_sync[SYNC_STAGES-1];
    assign w_oe_n      = r_oe_sync[SYNC_STAGES-1];
    assign w_stcp_rise = w_stcp & ~r_stcp_prev;
    assign w_shcp_rise = w_shcp & ~r_shcp_prev;

    // Input synchronizers and edge-detect history. OE resets high so the
    // outputs start out disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stcp_sync <= '0;
            r_shcp_sync <= '0;
            r_ds_sync   <= '0;
            r_oe_sync   <= '1;
            r_stcp_prev <= 1'b0;
            r_shcp_prev <= 1'b0;
        end else begin
            r_stcp_sync <= {r_stcp_sync[SYNC_STAGES-2:0], i_stcp};
            r_shcp_sync <= {r_shcp_sync[SYNC_STAGES-2:0], i_shcp};
            r_ds_sync   <= {r_ds_sync[SYNC_STAGES-2:0], i_ds};
            r_oe_sync   <= {r_oe_sync[SYNC_STAGES-2:0], i_oe};
            r_stcp_prev <= w_stcp;
            r_shcp_prev <= w_shcp;
        end
    end

    // Shift register. A shift and a latch in the same cycle both apply, and
    // the latch sees the pre-shift contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
        end else if (w_shcp_rise) begin
            r_shift <= {r_shift[WIDTH-2:0], w_ds};
        end
    end

    // Storage register, valid strobe, frame check and saturating bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_bit_cnt   <= '0;
        end else if (w_stcp_rise) begin
            r_data      <= r_shift;
            r_valid     <= 1'b1;
            r_frame_err <= (r_bit_cnt != W_CNT);
            // A coincident shift starts the new frame with one bit already in.
            r_bit_cnt   <= w_shcp_rise ? CNT_ONE : '0;
        end else begin
            r_valid <= 1'b0;
            if (w_shcp_rise && (r_bit_cnt != CNT_MAX)) begin
                r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
        end
    end

    assign o_shift     = r_shift;
    assign o_data      = r_data;
    assign o_q         = w_oe_n ? '0 : r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_hc595_rx.sv
// tb_hc595_rx: directed, table-driven bench for hc595_rx (WIDTH=16, SYNC_STAGES=2).
module tb_hc595_rx;

  localparam int WIDTH = 16;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(WIDTH + 2);

  logic             clk;
  logic             rst_n;
  logic             i_stcp;
  logic             i_shcp;
  logic             i_ds;
  logic             i_oe;
  logic [WIDTH-1:0] o_shift;
  logic [WIDTH-1:0] o_data;
  logic [WIDTH-1:0] o_q;
  logic             o_valid;
  logic             o_frame_err;
  logic [CW-1:0]    o_bit_cnt;

  int n_vec;
  int n_err;

  hc595_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_stcp(i_stcp), .i_shcp(i_shcp), .i_ds(i_ds), .i_oe(i_oe),
    .o_shift(o_shift), .o_data(o_data), .o_q(o_q),
    .o_valid(o_valid), .o_frame_err(o_frame_err), .o_bit_cnt(o_bit_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0]      bits;
    int               nbits;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
    logic [CW-1:0]    exp_cnt_pre;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // MSB-first; DS is held 4 clk before and 4 clk after each SHCP rise.
  task automatic send_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      i_ds   = bits[i];
      i_shcp = 1'b0;
      cyc(4);
      i_shcp = 1'b1;
      cyc(4);
    end
    i_shcp = 1'b0;
    cyc(4);
  endtask

  // STCP pulse; reports how many valid strobes were seen and at which sample.
  // Sample k=0 precedes the first edge that samples STCP high, so the valid
  // strobe is expected at k = SYNC+1.
  task automatic latch(output int vcnt, output int vpos);
    vcnt = 0;
    vpos = -1;
    @(posedge clk);
    #1 i_stcp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_valid) begin
        vcnt++;
        vpos = k;
      end
      if (k == 3) i_stcp = 1'b0;
    end
    cyc(2);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int vc, vp;
    string tag;
    tag = $sformatf("v%0d", idx);
    send_bits(v.bits, v.nbits);
    chk({tag, "_cnt_pre"}, 32'(o_bit_cnt), 32'(v.exp_cnt_pre));
    latch(vc, vp);
    chk({tag, "_valid_cnt"}, 32'(vc), 32'd1);
    chk({tag, "_valid_pos"}, 32'(vp), 32'(SYNC + 1));
    chk({tag, "_data"}, 32'(o_data), 32'(v.exp_data));
    chk({tag, "_err"}, 32'(o_frame_err), 32'(v.exp_err));
    chk({tag, "_cnt_post"}, 32'(o_bit_cnt), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int vc, vp;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0; i_stcp = 1'b0; i_shcp = 1'b0; i_ds = 1'b0; i_oe = 1'b0;

    //              bits                    n   data     err  cnt_pre
    vecs[0] = '{64'h0000_0000_0000_A5C3, 16, 16'hA5C3, 1'b0, 5'd16};
    vecs[1] = '{64'h0000_0000_0000_1234, 15, 16'h9234, 1'b1, 5'd15};
    vecs[2] = '{64'h0000_0000_0001_FFFF, 17, 16'hFFFF, 1'b1, 5'd17};
    vecs[3] = '{64'h0000_0000_0000_BEEF, 40, 16'hBEEF, 1'b1, 5'd31};
    vecs[4] = '{64'h0000_0000_0000_0000,  0, 16'hBEEF, 1'b1, 5'd0};
    vecs[5] = '{64'h0000_0000_0000_1234, 16, 16'h1234, 1'b0, 5'd16};

    cyc(3);
    chk("rst_shift", 32'(o_shift), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_q", 32'(o_q), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_err", 32'(o_frame_err), 32'd0);
    chk("rst_cnt", 32'(o_bit_cnt), 32'd0);
    rst_n = 1'b1;
    cyc(4);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // OE gating: o_data is 0x1234 here.
    @(posedge clk);
    #1 i_oe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == SYNC - 1) chk("oe_on_before", 32'(o_q), 32'h1234);
      if (k == SYNC)     chk("oe_on_after", 32'(o_q), 32'h0);
    end
    chk("oe_on_data", 32'(o_data), 32'h1234);
    chk("oe_on_shift", 32'(o_shift), 32'h1234);
    @(posedge clk);
    #1 i_oe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == SYNC - 1) chk("oe_off_before", 32'(o_q), 32'h0);
      if (k == SYNC)     chk("oe_off_after", 32'(o_q), 32'h1234);
    end
    chk("oe_off_data", 32'(o_data), 32'h1234);

    // Simultaneous SHCP/STCP rise after 16 ones, DS=0 on that edge.
    send_bits(64'hFFFF, 16);
    i_ds = 1'b0;
    cyc(4);
    i_shcp = 1'b1;
    i_stcp = 1'b1;
    vc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_valid) vc++;
    end
    chk("sim_valid_cnt", 32'(vc), 32'd1);
    chk("sim_data", 32'(o_data), 32'hFFFF);
    chk("sim_shift", 32'(o_shift), 32'hFFFE);
    chk("sim_cnt", 32'(o_bit_cnt), 32'd1);
    chk("sim_err", 32'(o_frame_err), 32'd0);
    cyc(1);
    i_shcp = 1'b0;
    i_stcp = 1'b0;
    cyc(4);

    // Reset mid-frame, with o_data nonzero beforehand.
    send_bits(64'hA5, 8);
    chk("pre_rst_cnt", 32'(o_bit_cnt), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(o_q), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("in_rst_q", 32'(o_q), 32'd0);
      chk("in_rst_data", 32'(o_data), 32'd0);
    end
    chk("in_rst_shift", 32'(o_shift), 32'd0);
    chk("in_rst_cnt", 32'(o_bit_cnt), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    send_bits(64'h0F0F, 16);
    chk("post_rst_cnt", 32'(o_bit_cnt), 32'd16);
    latch(vc, vp);
    chk("post_rst_valid", 32'(vc), 32'd1);
    chk("post_rst_data", 32'(o_data), 32'h0F0F);
    chk("post_rst_err", 32'(o_frame_err), 32'd0);
    chk("post_rst_q", 32'(o_q), 32'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
